// File: rtl/proc_result_checker.sv
// -----------------------------------------------------------------------------
// proc_result_checker
//
// Result checker placed directly after the single-cycle processor. It holds a
// small table of (checkpoint PC, expected writeback value) pairs. During a run
// it waits for the processor PC to reach each checkpoint in table order. It
// then compares MemtoRegOut against the expected value, counts passes and
// failures, and stops with TIMEOUT if the run takes too long. This lets the
// same self-check run on an FPGA without a simulator bench loop.
//
// Ports
//   CLK               rising-edge clock, shared with the processor
//   resetl            asynchronous active-low reset
//   cfg_we            table write strobe (ignored while busy)
//   cfg_idx           table entry to write
//   cfg_pc            checkpoint PC for the entry
//   cfg_value         expected MemtoRegOut for the entry
//   start             single-cycle pulse that begins a checking run
//   currentpc         processor PC
//   MemtoRegOut       processor writeback value
//   busy              run in progress
//   done              run finished, every entry resolved
//   timeout           run aborted by the cycle watchdog
//   all_passed        done with every entry matching
//   pass_count        entries that matched
//   fail_count        entries that mismatched
//   first_fail_idx    table index of the first mismatch
//   first_fail_actual MemtoRegOut captured at the first mismatch
//   cycle_count       run cycles elapsed (saturating)
//
// Every output comes straight from a register or from a decode of the state
// register. No input reaches an output without passing through a flop.
// -----------------------------------------------------------------------------
module proc_result_checker #(
  parameter int          NUM_CHECKS     = 2,
  parameter logic [15:0] WATCHDOG_LIMIT = 16'h00FF,
  parameter int          IDXW           = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  parameter int          CNTW           = $clog2(NUM_CHECKS + 1)
) (
  input  logic            CLK,
  input  logic            resetl,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [63:0]     cfg_pc,
  input  logic [63:0]     cfg_value,
  input  logic            start,
  input  logic [63:0]     currentpc,
  input  logic [63:0]     MemtoRegOut,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic            all_passed,
  output logic [CNTW-1:0] pass_count,
  output logic [CNTW-1:0] fail_count,
  output logic [IDXW-1:0] first_fail_idx,
  output logic [63:0]     first_fail_actual,
  output logic [15:0]     cycle_count
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  // ---------------------------------------------------------------------------
  // Registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] pass_q, pass_d;
  logic [CNTW-1:0] fail_q, fail_d;
  logic [IDXW-1:0] ffi_q, ffi_d;
  logic [63:0]     ffa_q, ffa_d;
  logic [15:0]     cyc_q, cyc_d;
  logic            all_passed_q, all_passed_d;

  // Checkpoint table
  logic [63:0] tbl_pc_q  [NUM_CHECKS];
  logic [63:0] tbl_val_q [NUM_CHECKS];

  // ---------------------------------------------------------------------------
  // Datapath decode for the entry under check
  // ---------------------------------------------------------------------------
  logic [63:0] check_pc;
  logic [63:0] check_val;
  logic        check_hit;    // PC has reached the checkpoint
  logic        check_last;   // current entry is the final one
  logic        wd_expire;    // this RUN cycle is the last one the watchdog allows
  logic        tbl_we;

  // idx_q stays within 0..NUM_CHECKS-1 because it never advances past the last
  // entry, so the table read below is always in range.
  assign check_pc   = tbl_pc_q[idx_q];
  assign check_val  = tbl_val_q[idx_q];
  assign check_hit  = (currentpc >= check_pc);
  assign check_last = (int'(idx_q) == NUM_CHECKS - 1);
  assign wd_expire  = (cyc_q == (WATCHDOG_LIMIT - 16'd1));

  // Table writes are accepted in every state except RUN, including the cycle
  // that start is seen. Out-of-range indices are dropped.
  assign tbl_we = cfg_we && (state_q != ST_RUN) && (int'(cfg_idx) < NUM_CHECKS);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through the
  // block leaves a value unassigned and no latch can be inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    ffi_d        = ffi_q;
    ffa_d        = ffa_q;
    cyc_d        = cyc_q;
    all_passed_d = all_passed_q;

    unique case (state_q)
      ST_RUN: begin
        if (cyc_q != 16'hFFFF) begin
          cyc_d = cyc_q + 16'd1;
        end

        // At most one entry resolves per cycle, against this cycle's value.
        if (check_hit) begin
          if (MemtoRegOut == check_val) begin
            pass_d = pass_q + CNTW'(1);
          end else begin
            fail_d = fail_q + CNTW'(1);
            if (fail_q == '0) begin
              ffi_d = idx_q;
              ffa_d = MemtoRegOut;
            end
          end
          if (!check_last) begin
            idx_d = idx_q + IDXW'(1);
          end
        end

        // If the final check and the watchdog fire in the same cycle, the check
        // result is kept and the run ends in DONE.
        if (check_hit && check_last) begin
          state_d      = ST_DONE;
          all_passed_d = (pass_d == CNTW'(NUM_CHECKS));
        end else if (wd_expire) begin
          state_d = ST_TIMEOUT;
        end
      end

      // IDLE, DONE and TIMEOUT: hold everything until start arrives.
      default: begin
        if (start) begin
          state_d      = ST_RUN;
          idx_d        = '0;
          pass_d       = '0;
          fail_d       = '0;
          ffi_d        = '0;
          ffa_d        = '0;
          cyc_d        = '0;
          all_passed_d = 1'b0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and result registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pass_q       <= '0;
      fail_q       <= '0;
      ffi_q        <= '0;
      ffa_q        <= '0;
      cyc_q        <= '0;
      all_passed_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      ffi_q        <= ffi_d;
      ffa_q        <= ffa_d;
      cyc_q        <= cyc_d;
      all_passed_q <= all_passed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Checkpoint table
  // ---------------------------------------------------------------------------
  // NOTE: the table is deliberately reset. A run started with an unwritten
  // table must see all-zero entries, so the table is built from resettable
  // flops rather than a RAM macro.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < NUM_CHECKS; i++) begin
        tbl_pc_q[i]  <= '0;
        tbl_val_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_pc_q[cfg_idx]  <= cfg_pc;
      tbl_val_q[cfg_idx] <= cfg_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy              = (state_q == ST_RUN);
  assign done              = (state_q == ST_DONE);
  assign timeout           = (state_q == ST_TIMEOUT);
  assign all_passed        = all_passed_q;
  assign pass_count        = pass_q;
  assign fail_count        = fail_q;
  assign first_fail_idx    = ffi_q;
  assign first_fail_actual = ffa_q;
  assign cycle_count       = cyc_q;

endmodule
